// File: rtl/swd_target_pkg.sv
// Shared types and constants for the SWD target Debug Port.
package swd_target_pkg;
    typedef enum logic [3:0] {
        LOCKOUT, IDLE, HDR, TRN1, ACK, RDATA, TRN2, WTRN, WDATA
    } state_t;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [1:0] DP_IDCODE_ABORT  = 2'd0;
    localparam logic [1:0] DP_CTRLSTAT      = 2'd1;
    localparam logic [1:0] DP_SELECT_RESEND = 2'd2;
    localparam logic [1:0] DP_RDBUFF        = 2'd3;

    localparam int CS_STICKYERR = 5;
    localparam int CS_WDATAERR  = 7;
    localparam int CS_B28       = 28;
    localparam int CS_B29       = 29;
    localparam int CS_B30       = 30;
    localparam int CS_B31       = 31;

    localparam int AB_DAPABORT  = 0;
    localparam int AB_STKERRCLR = 2;
    localparam int AB_WDERRCLR  = 3;
endpackage

// File: rtl/swd_target_dp_if.sv
// AP backend handshake between the Debug Port (master) and the local AP (slave).
interface swd_target_dp_if;
    logic        AP_REQ;
    logic        AP_RnW;
    logic [7:0]  AP_APSEL;
    logic [7:0]  AP_ADDR;
    logic [31:0] AP_WDATA;
    logic        AP_ACK;
    logic [31:0] AP_RDATA;
    logic        AP_ERR;

    modport master (output AP_REQ, AP_RnW, AP_APSEL, AP_ADDR, AP_WDATA,
                    input  AP_ACK, AP_RDATA, AP_ERR);
    modport slave  (input  AP_REQ, AP_RnW, AP_APSEL, AP_ADDR, AP_WDATA,
                    output AP_ACK, AP_RDATA, AP_ERR);
endinterface

// File: rtl/swd_target_sync.sv
// 2FF synchronizers for SWCLK/SWDIO plus SWCLK rising-edge detect in CLK domain.
module swd_target_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic SWCLK,
    input  logic SWDIO_I,
    output logic rise,
    output logic din
);
    logic [2:0] clk_s;
    logic [1:0] dio_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_s <= '0;
            dio_s <= '0;
        end else begin
            clk_s <= {clk_s[1:0], SWCLK};
            dio_s <= {dio_s[0], SWDIO_I};
        end
    end

    // data and clock go through equal depth so din is aligned with rise
    assign rise = clk_s[1] & ~clk_s[2];
    assign din  = dio_s[1];
endmodule

// File: rtl/swd_target_dp.sv
// SWD target Debug Port: header decode, ACK/data drive, DP registers and
// posted AP access forwarding over a req/ack handshake.
module swd_target_dp
    import swd_target_pkg::*;
#(
    parameter logic [31:0] IDCODE    = 32'h2BA01477,
    parameter int          LRST_BITS = 50
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SWCLK,
    input  logic SWDIO_I,
    output logic SWDIO_O,
    output logic SWDIO_OE,
    swd_target_dp_if.master ap
);
    localparam int LW = $clog2(LRST_BITS);
    localparam logic [LW-1:0] LRST_MAX = LW'(LRST_BITS - 1);

    logic rise, din;
    state_t state, nxt;
    logic [5:0] cnt;
    logic [31:0] sh, rdat, rsel, rdbuff, ctrlstat, ap_wdata;
    logic [LW-1:0] lrst_cnt;
    logic r_apndp, r_rnw, rpar, oe, o, c28, c30, sticky, wderr, busy, ap_rnw;
    logic [1:0] r_a;
    logic [2:0] ack_r, ack_nxt;
    logic [7:0] sel_apsel, ap_apsel, ap_addr;
    logic [3:0] sel_bank;
    logic hdr_ok, lrst_hit, par_ok, dapabort;

    swd_target_sync u_sync (.CLK(CLK), .RESET(RESET), .SWCLK(SWCLK), .SWDIO_I(SWDIO_I),
                            .rise(rise), .din(din));

    // header bits 1..6 sit in sh[26..31] when park arrives on din
    assign hdr_ok   = (sh[30] == ^sh[29:26]) & ~sh[31] & din;
    assign lrst_hit = ~oe & din & (lrst_cnt == LRST_MAX);
    assign par_ok   = (din == ^sh);
    assign dapabort = rise & (state == WDATA) & (cnt == 6'd32) & par_ok & ~r_apndp
                    & (r_a == DP_IDCODE_ABORT) & sh[AB_DAPABORT];

    always_comb begin
        ctrlstat               = '0;
        ctrlstat[CS_B31]       = c30;
        ctrlstat[CS_B30]       = c30;
        ctrlstat[CS_B29]       = c28;
        ctrlstat[CS_B28]       = c28;
        ctrlstat[CS_WDATAERR]  = wderr;
        ctrlstat[CS_STICKYERR] = sticky;
        rsel = rdbuff;
        if (!r_apndp) begin
            case (r_a)
                DP_IDCODE_ABORT: rsel = IDCODE;
                DP_CTRLSTAT:     rsel = ctrlstat;
                default:         rsel = rdbuff;
            endcase
        end
        if (r_apndp)
            ack_nxt = (sticky | wderr) ? ACK_FAULT : (busy ? ACK_WAIT : ACK_OK);
        else
            ack_nxt = (r_rnw && r_a == DP_RDBUFF && busy) ? ACK_WAIT : ACK_OK;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (din) nxt = HDR;
            HDR:     if (cnt == 6'd6) nxt = hdr_ok ? TRN1 : LOCKOUT;
            TRN1:    nxt = ACK;
            ACK:     if (cnt == 6'd2) nxt = (ack_r != ACK_OK) ? TRN2 : (r_rnw ? RDATA : WTRN);
            RDATA:   if (cnt == 6'd32) nxt = TRN2;
            TRN2:    nxt = IDLE;
            WTRN:    nxt = WDATA;
            WDATA:   if (cnt == 6'd32) nxt = IDLE;
            default: nxt = state;
        endcase
        if (lrst_hit) nxt = IDLE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= LOCKOUT;
            cnt   <= '0;
        end else if (rise) begin
            state <= nxt;
            cnt   <= (nxt != state) ? 6'd0 : cnt + 6'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            oe <= 1'b0; o <= 1'b0; sh <= '0; lrst_cnt <= '0;
            r_apndp <= 1'b0; r_rnw <= 1'b0; r_a <= '0; ack_r <= '0;
            rdat <= '0; rpar <= 1'b0; sel_apsel <= '0; sel_bank <= '0;
            c28 <= 1'b0; c30 <= 1'b0; rdbuff <= '0; sticky <= 1'b0; wderr <= 1'b0;
            busy <= 1'b0; ap_rnw <= 1'b0; ap_apsel <= '0; ap_addr <= '0; ap_wdata <= '0;
        end else begin
            // an abort in the same cycle discards the backend response
            if (busy && ap.AP_ACK && !dapabort) begin
                busy <= 1'b0;
                if (ap_rnw) rdbuff <= ap.AP_RDATA;
                if (ap.AP_ERR) sticky <= 1'b1;
            end
            if (rise) begin
                sh <= {din, sh[31:1]};
                if (oe || !din) lrst_cnt <= '0;
                else if (lrst_cnt != LRST_MAX) lrst_cnt <= lrst_cnt + LW'(1);
                case (state)
                    HDR: if (cnt == 6'd6) begin
                        r_apndp <= sh[26];
                        r_rnw   <= sh[27];
                        r_a     <= sh[29:28];
                    end
                    TRN1: begin
                        oe    <= 1'b1;
                        o     <= ack_nxt[0];
                        ack_r <= ack_nxt;
                    end
                    ACK: begin
                        if (cnt == 6'd0) o <= ack_r[1];
                        else if (cnt == 6'd1) o <= ack_r[2];
                        else if (ack_r == ACK_OK && r_rnw) begin
                            o    <= rsel[0];
                            rdat <= rsel;
                            rpar <= ^rsel;
                            if (r_apndp) begin
                                busy     <= 1'b1;
                                ap_rnw   <= 1'b1;
                                ap_apsel <= sel_apsel;
                                ap_addr  <= {sel_bank, r_a, 2'b00};
                            end
                        end else begin
                            oe <= 1'b0;
                            o  <= 1'b0;
                        end
                    end
                    RDATA: begin
                        if (cnt < 6'd31) begin
                            o    <= rdat[1];
                            rdat <= rdat >> 1;
                        end else if (cnt == 6'd31) o <= rpar;
                        else begin
                            oe <= 1'b0;
                            o  <= 1'b0;
                        end
                    end
                    WDATA: if (cnt == 6'd32) begin
                        if (!par_ok) wderr <= 1'b1;
                        else if (r_apndp) begin
                            busy     <= 1'b1;
                            ap_rnw   <= 1'b0;
                            ap_apsel <= sel_apsel;
                            ap_addr  <= {sel_bank, r_a, 2'b00};
                            ap_wdata <= sh;
                        end else begin
                            case (r_a)
                                DP_IDCODE_ABORT: begin
                                    if (sh[AB_DAPABORT])  busy   <= 1'b0;
                                    if (sh[AB_STKERRCLR]) sticky <= 1'b0;
                                    if (sh[AB_WDERRCLR])  wderr  <= 1'b0;
                                end
                                DP_CTRLSTAT: begin
                                    c28 <= sh[CS_B28];
                                    c30 <= sh[CS_B30];
                                end
                                DP_SELECT_RESEND: begin
                                    sel_apsel <= sh[31:24];
                                    sel_bank  <= sh[7:4];
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
                if (lrst_hit) begin
                    oe <= 1'b0;
                    o  <= 1'b0;
                end
            end
        end
    end

    assign SWDIO_O     = o;
    assign SWDIO_OE    = oe;
    assign ap.AP_REQ   = busy;
    assign ap.AP_RnW   = ap_rnw;
    assign ap.AP_APSEL = ap_apsel;
    assign ap.AP_ADDR  = ap_addr;
    assign ap.AP_WDATA = ap_wdata;
endmodule

// File: doc/swd_target_dp.md
Name: swd_target_dp

Overview:
SWD target-side Debug Port and the responder end of the SWD link driven by our host ADIv5 bridge. It oversamples SWCLK/SWDIO in the CLK domain and decodes request headers. It drives ACK, read data and parity, and serves DP registers internally. AP accesses are forwarded to a local AP backend over a req/ack handshake with ADIv5 posted-read semantics. It is used for loopback verification of the bridge and as a target stub in FPGA systems.

Parameters:
IDCODE, 32'h2BA01477, value returned on DP[0x0] read
LRST_BITS, 50, consecutive high SWDIO bits at SWCLK rise that form a line reset

Ports:
CLK  in  1  system clock; must be >= 8x SWCLK
RESET  in  1  asynchronous, active-high reset
SWCLK  in  1  SWD clock from host, asynchronous to CLK
SWDIO_I  in  1  SWDIO input
SWDIO_O  out  1  SWDIO output data
SWDIO_OE  out  1  SWDIO output enable
AP_REQ  out  1  AP access request; level signal
AP_RnW  out  1  1 = AP read
AP_APSEL  out  8  SELECT[31:24]
AP_ADDR  out  8  {SELECT[7:4], A[3:2], 2'b00}
AP_WDATA  out  32  AP write data
AP_ACK  in  1  one-CLK completion pulse
AP_RDATA  in  32  read data, valid with AP_ACK
AP_ERR  in  1  error, valid with AP_ACK

Behaviour:
- Reset (asynchronous, active-high) values: SWDIO_OE=0, SWDIO_O=0, AP_REQ=0, AP_RnW=0, AP_APSEL=0, AP_ADDR=0, AP_WDATA=0. Internal: SELECT=0, CTRL/STAT=0, RDBUFF=0, STICKYERR=0, WDATAERR=0, busy=0, state=LOCKOUT.
- SWCLK and SWDIO_I each pass through a 2FF synchronizer; a rising edge of SWCLK is detected on the synced value.
- All sampling and all output updates occur only on a detected rising edge (rise). Output updates therefore trail the physical edge by 3 CLK.
- Header is 8 bits, LSB first: Start=1, APnDP, RnW, A[2], A[3], Parity=^{APnDP,RnW,A}, Stop=0, Park=1.
- States:
  - LOCKOUT: not driving.
  - IDLE: waits for a sampled 1.
  - HDR: collects 7 more bits.
  - TRN1: one turnaround bit; OE is asserted on the rise that ends TRN1.
  - ACK: 3 bits, bit0 first. OK=3'b001, WAIT=3'b010, FAULT=3'b100.
  - Read with OK: RDATA, 32 bits LSB first then even parity bit, then TRN2 (OE=0) -> IDLE.
  - Write with OK: WTRN (OE=0), then WDATA (32 bits plus parity, sampled) -> IDLE.
  - WAIT or FAULT: TRN2 -> IDLE. No data phase.
- Line reset: LRST_BITS consecutive sampled 1s, counted only while the target is not driving. It forces state to LOCKOUT-exit (IDLE-ready) from any state, aborts the data phase, and does not alter registers.
- Header protocol error (bad parity, Stop!=0 or Park!=1): target never drives; state -> LOCKOUT until a line reset.
- DP A=0:
  - Read returns IDCODE.
  - Write is ABORT. Bit0 DAPABORT drops AP_REQ, clears busy and discards the pending response. Bit2 clears STICKYERR. Bit3 clears WDATAERR.
- DP A=1, CTRL/STAT:
  - Bits [31:28]: bit29 is a read-only mirror of bit28, bit31 is a read-only mirror of bit30. Bits 28 and 30 are R/W.
  - Bit5 is STICKYERR, bit7 is WDATAERR; both read-only.
  - All other bits read as 0.
- DP A=2: write loads SELECT; read returns RDBUFF (RESEND).
- DP A=3: read returns RDBUFF; write is ignored with ACK OK.
- AP access:
  - ACK=FAULT if STICKYERR or WDATAERR is set; else ACK=WAIT if busy; else ACK=OK.
  - A DP RDBUFF read while busy also returns WAIT. Other DP accesses always return OK.
  - AP read with OK: returns the current RDBUFF (posted) and raises AP_REQ at the end of ACK.
  - AP write with OK: raises AP_REQ after the WDATA parity check passes.
  - On AP_ACK: AP_REQ=0, busy=0, RDBUFF<=AP_RDATA if the access was a read, STICKYERR set if AP_ERR.
- Write data parity error: WDATAERR=1, register or AP is not updated, no AP_REQ.
- Simultaneous AP_ACK and DAPABORT write: the abort wins and the response is discarded.
- AP_REQ and its address/data stay stable until AP_ACK or abort.
- Bit counter is 6 bits wide and is cleared on each state entry.

Decomposition:
- swd_target_pkg holds:
  - the state_t enum
  - ACK_OK/WAIT/FAULT constants
  - DP address constants (DP_IDCODE_ABORT=0, DP_CTRLSTAT=1, DP_SELECT_RESEND=2, DP_RDBUFF=3)
  - the CTRL/STAT bit indices
- One sub-module: swd_target_sync, the 2FF synchronizers plus the SWCLK rise detector.

Test Plan:
- 56 ones, 2 zeros, header 0xA5 (IDCODE read) -> ACK 3'b001, data 32'h2BA01477, parity 0, OE released at TRN2.
- Header 0xA1 (bad parity) after line reset -> SWDIO_OE stays 0 through 46 clocks; subsequent valid header ignored until a 56-one line reset, then IDCODE read returns OK.
- Sequence: SELECT write 32'h0100_00F0, then AP write A=1 data 32'h12345678.
  - Expect AP_REQ with AP_APSEL=8'h01, AP_ADDR=8'hF4, AP_WDATA=32'h12345678.
  - Hold AP_ACK off; a second AP access must return ACK WAIT.
- AP read A=3: first returns the old RDBUFF (0); backend acks with 32'hDEADBEEF; then RDBUFF read returns 32'hDEADBEEF with ACK OK.
- Backend returns AP_ERR=1:
  - CTRL/STAT read shows bit5 set and the next AP access gets FAULT.
  - ABORT write 32'h4 clears it and the next AP access gets OK.
- Write CTRL/STAT 32'h5000_0000 -> readback 32'hF000_0000. DP write with flipped data parity -> CTRL/STAT bit7 set and value unchanged.
